writeback_unit: RTL and testbench

- Final pipeline stage that feeds the 32x32 register bank's single write port (we / sel_in / data_in).
- Accepts completed results from the ALU path and the load path over valid/ready handshakes and arbitrates one write per cycle.
- Sign/zero-extends load data by funct3 and byte offset.
- Keeps a pending-write scoreboard that decode uses for RAW hazard stalls.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/load_formatter.sv | 50 +++++
 rtl/writeback_unit.sv | 100 ++++++++++
 tb/tb_writeback_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the writeback stage: datapath widths,
// load funct3 encodings and the writeback source tag used for arbitration.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/load_formatter.sv
// Combinational load data extraction: selects the byte/half/word addressed by
// addr_lo, sign- or zero-extends it, and flags misaligned or illegal loads.
module load_formatter
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            fault
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata[7:0];
    case (addr_lo)
      2'd0: byte_val = rdata[7:0];
      2'd1: byte_val = rdata[15:8];
      2'd2: byte_val = rdata[23:16];
      2'd3: byte_val = rdata[31:24];
      default: byte_val = rdata[7:0];
    endcase
    half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_val[7]}}, byte_val};
      F3_LBU: data = {24'b0, byte_val};
      F3_LH: begin
        data  = {{16{half_val[15]}}, half_val};
        fault = addr_lo[0];
      end
      F3_LHU: begin
        data  = {16'b0, half_val};
        fault = addr_lo[0];
      end
      F3_LW: begin
        data  = rdata;
        fault = (addr_lo != 2'b00);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: round-robin arbitration between ALU and load results
// onto the register bank write port, plus the pending-write scoreboard.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REG_AW-1:0]        alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [REG_AW-1:0]        mem_rd,
  input  logic [2:0]               mem_funct3,
  input  logic [1:0]               mem_addr_lo,
  input  logic [XLEN-1:0]          mem_rdata,
  input  logic                     issue_valid,
  input  logic [REG_AW-1:0]        issue_rd,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_sel,
  output logic [XLEN-1:0]          rf_data,
  output logic [(1<<REG_AW)-1:0]   pending,
  output logic                     load_fault
);

  wb_src_e                   rr_last;
  logic                      conflict;
  logic                      alu_fire;
  logic                      mem_fire;
  logic [XLEN-1:0]           fmt_data;
  logic                      fmt_fault;
  logic                      wr_fire;
  logic                      wr_fault;
  logic [REG_AW-1:0]         wr_rd;
  logic [XLEN-1:0]           wr_data;
  logic [(1<<REG_AW)-1:0]    pending_nxt;

  load_formatter u_load_formatter (
    .funct3  (mem_funct3),
    .addr_lo (mem_addr_lo),
    .rdata   (mem_rdata),
    .data    (fmt_data),
    .fault   (fmt_fault)
  );

  // On a conflict the source not granted last time wins; otherwise everyone is ready.
  assign conflict  = alu_valid && mem_valid;
  assign alu_ready = !conflict || (rr_last == WB_MEM);
  assign mem_ready = !conflict || (rr_last == WB_ALU);
  assign alu_fire  = alu_valid && alu_ready;
  assign mem_fire  = mem_valid && mem_ready;

  always_comb begin
    wr_fire  = alu_fire || mem_fire;
    wr_fault = 1'b0;
    wr_rd    = alu_rd;
    wr_data  = alu_data;
    if (mem_fire) begin
      wr_rd    = mem_rd;
      wr_data  = fmt_data;
      wr_fault = fmt_fault;
    end
  end

  // Clear before set so a same-edge issue to the same rd stays pending.
  always_comb begin
    pending_nxt = pending;
    if (wr_fire)
      pending_nxt[wr_rd] = 1'b0;
    if (issue_valid)
      pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_sel     <= '0;
      rf_data    <= '0;
      pending    <= '0;
      load_fault <= 1'b0;
      rr_last    <= WB_ALU;
    end else begin
      rf_we      <= wr_fire && !wr_fault && (wr_rd != '0);
      load_fault <= wr_fire && wr_fault;
      pending    <= pending_nxt;
      if (wr_fire) begin
        rf_sel  <= wr_rd;
        rf_data <= wr_data;
      end
      if (conflict)
        rr_last <= alu_fire ? WB_ALU : WB_MEM;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed scenarios then random traffic,
// checked against a transaction-level model of arbitration, loads and pending.
module tb_writeback_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [2:0]  mem_funct3 = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic [31:0] mem_rdata = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        rf_we;
  logic [4:0]  rf_sel;
  logic [31:0] rf_data;
  logic [31:0] pending;
  logic        load_fault;

  writeback_unit dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_funct3(mem_funct3),
    .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_we(rf_we), .rf_sel(rf_sel), .rf_data(rf_data),
    .pending(pending), .load_fault(load_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    bit          we;
    bit [4:0]    sel;
    bit [31:0]   data;
    bit          fault;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          last_mem = 1'b0;   // model: previous conflict went to the load path
  bit [31:0]   mp = '0;           // model pending set

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void fmt(input bit [2:0] f3, input bit [1:0] lo, input bit [31:0] w,
                              output bit [31:0] d, output bit flt);
    bit [31:0] b;
    bit [31:0] h;
    b = (w >> (lo * 8)) & 32'hFF;
    h = (w >> (lo[1] * 16)) & 32'hFFFF;
    d = 0;
    flt = 0;
    case (f3)
      3'd0: d = (b >= 128) ? b - 256 : b;
      3'd4: d = b;
      3'd1: begin d = (h >= 32768) ? h - 65536 : h; flt = (lo % 2) != 0; end
      3'd5: begin d = h; flt = (lo % 2) != 0; end
      3'd2: begin d = w; flt = (lo != 0); end
      default: flt = 1;
    endcase
  endfunction

  task automatic step(input bit av, input bit [4:0] ard, input bit [31:0] ad,
                      input bit mv, input bit [4:0] mrd, input bit [2:0] f3,
                      input bit [1:0] lo, input bit [31:0] w,
                      input bit iv, input bit [4:0] ird);
    int   grant;   // 0 none, 1 alu, 2 mem
    exp_t e;
    bit [31:0] d;
    bit   flt;
    @(negedge clock);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_funct3 = f3; mem_addr_lo = lo; mem_rdata = w;
    issue_valid = iv; issue_rd = ird;
    #1;
    if (av && mv) grant = last_mem ? 1 : 2;
    else if (av) grant = 1;
    else if (mv) grant = 2;
    else grant = 0;
    if (av) chk("alu_ready", alu_ready, (grant == 1));
    if (mv) chk("mem_ready", mem_ready, (grant == 2));
    if (!av && !mv) chk("idle_readies", {alu_ready, mem_ready}, 2'b11);
    if (av && mv) last_mem = (grant == 2);
    e.cyc = cyc + 1; e.we = 0; e.sel = 0; e.data = 0; e.fault = 0;
    if (grant == 1) begin
      mp[ard] = 0;
      if (ard != 0) begin e.we = 1; e.sel = ard; e.data = ad; q.push_back(e); end
    end else if (grant == 2) begin
      mp[mrd] = 0;
      fmt(f3, lo, w, d, flt);
      if (flt) begin e.fault = 1; q.push_back(e); end
      else if (mrd != 0) begin e.we = 1; e.sel = mrd; e.data = d; q.push_back(e); end
    end
    if (iv && ird != 0) mp[ird] = 1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always begin
    exp_t e;
    @(posedge clock);
    #2;
    if (mon_en && !reset) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("rf_we", rf_we, e.we);
        chk("load_fault", load_fault, e.fault);
        if (e.we) begin
          chk("rf_sel", rf_sel, e.sel);
          chk("rf_data", rf_data, e.data);
        end
      end else begin
        chk("idle_rf_we", rf_we, 0);
        chk("idle_load_fault", load_fault, 0);
      end
      chk("pending", pending, mp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_sel", rf_sel, 0);
    chk("reset_rf_data", rf_data, 0);
    chk("reset_pending", pending, 0);
    chk("reset_load_fault", load_fault, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // ALU write with a pending destination
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    step(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
    // load extension table
    step(0, 0, 0, 1, 10, 3'b000, 2'd3, 32'h80FF_7F01, 0, 0);
    step(0, 0, 0, 1, 11, 3'b100, 2'd3, 32'h80FF_7F01, 0, 0);
    step(0, 0, 0, 1, 12, 3'b001, 2'd2, 32'h80FF_7F01, 0, 0);
    step(0, 0, 0, 1, 13, 3'b101, 2'd0, 32'h80FF_7F01, 0, 0);
    step(0, 0, 0, 1, 14, 3'b010, 2'd0, 32'h80FF_7F01, 0, 0);
    // back-to-back conflicts
    step(1, 1, 32'hA1, 1, 2, 3'b010, 2'd0, 32'hB1, 0, 0);
    step(1, 1, 32'hA1, 1, 2, 3'b010, 2'd0, 32'hB2, 0, 0);
    step(1, 3, 32'hA3, 1, 2, 3'b010, 2'd0, 32'hB3, 0, 0);
    // misaligned word load and x0 destination
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    step(0, 0, 0, 1, 7, 3'b010, 2'd2, 32'hDEAD_BEEF, 0, 0);
    step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 8, 3'b111, 2'd0, 32'h1, 0, 0);
    // same-edge issue and retire of x9, then retire
    step(1, 9, 32'h99, 0, 0, 0, 0, 0, 1, 9);
    step(1, 9, 32'h9A, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // async reset between accept and write-out
    @(negedge clock);
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33; mem_valid = 0;
    issue_valid = 1; issue_rd = 12;
    mon_en = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_rf_we", rf_we, 0);
    chk("async_rst_pending", pending, 0);
    chk("async_rst_rf_data", rf_data, 0);
    chk("async_rst_load_fault", load_fault, 0);
    q.delete();
    mp = '0;
    last_mem = 1'b0;
    @(negedge clock);
    alu_valid = 0; issue_valid = 0;
    reset = 1'b0;
    mon_en = 1'b1;
    step(1, 4, 32'h44, 1, 6, 3'b100, 2'd1, 32'h0000_8000, 0, 0);
    step(1, 4, 32'h45, 1, 6, 3'b000, 2'd1, 32'h0000_8000, 0, 0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 55), 5'($urandom), $urandom,
           ($urandom_range(0, 99) < 55), 5'($urandom), 3'($urandom), 2'($urandom), $urandom,
           ($urandom_range(0, 99) < 40), 5'($urandom));
    end
    repeat (3) idle();
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
